// File: rtl/bus_pkg.sv
// Shared types and defaults for the host-to-N-device bus hub.
package bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hub_state_t;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Index width that never collapses to zero bits for tiny counts.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_hub_n_if.sv
// Host request/response and per-device bus bundle for bus_hub_n.
interface bus_hub_n_if #(
    parameter int unsigned N_DEVICES = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
);
    logic [ADDR_W-1:0]             host_address;
    logic [DATA_W-1:0]             host_data_write;
    logic [DATA_W/8-1:0]           host_write_mask;
    logic                          host_ren;
    logic                          host_wen;
    logic [DATA_W-1:0]             host_data_read;
    logic                          host_ready;
    logic                          host_error;
    logic [N_DEVICES*ADDR_W-1:0]   device_address;
    logic [N_DEVICES*DATA_W-1:0]   device_data_write;
    logic [N_DEVICES*DATA_W/8-1:0] device_write_mask;
    logic [N_DEVICES-1:0]          device_ren;
    logic [N_DEVICES-1:0]          device_wen;
    logic [N_DEVICES-1:0]          device_ready;
    logic [N_DEVICES*DATA_W-1:0]   device_data_read;
    logic [N_DEVICES-1:0]          device_active;
    logic [7:0]                    err_count;

    // Environment side: drives host requests and device responses.
    modport master (
        output host_address, host_data_write, host_write_mask, host_ren, host_wen,
        output device_ready, device_data_read, device_active,
        input  host_data_read, host_ready, host_error,
        input  device_address, device_data_write, device_write_mask,
        input  device_ren, device_wen, err_count
    );

    // Hub side.
    modport slave (
        input  host_address, host_data_write, host_write_mask, host_ren, host_wen,
        input  device_ready, device_data_read, device_active,
        output host_data_read, host_ready, host_error,
        output device_address, device_data_write, device_write_mask,
        output device_ren, device_wen, err_count
    );

endinterface

// File: rtl/prio_encoder_n.sv
// N-bit priority encoder: index of the highest set bit plus an any-set flag.
module prio_encoder_n #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Later (higher) bits overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i]) idx = IW'(i);
        end
    end

    assign valid = |vec;

endmodule

// File: rtl/bus_hub_n.sv
// Host-to-N-device bus hub: latches the selected device per access, answers
// unmapped and timed-out accesses with an error, counts error completions.
module bus_hub_n
    import bus_pkg::*;
#(
    parameter int unsigned        N_DEVICES = 4,
    parameter int unsigned        ADDR_W    = ADDR_W_DEFAULT,
    parameter int unsigned        DATA_W    = DATA_W_DEFAULT,
    parameter int unsigned        TIMEOUT   = 255,
    parameter logic [DATA_W-1:0]  ERR_DATA  = DATA_W'(ERR_DATA_DEFAULT)
) (
    input logic        clk,
    input logic        rst,
    bus_hub_n_if.slave bus
);

    localparam int unsigned IW = width_of(N_DEVICES);
    localparam int unsigned WW = width_of(TIMEOUT + 1);
    localparam int unsigned MW = DATA_W / 8;

    hub_state_t    state, state_n;
    logic [IW-1:0] sel_idx, sel_idx_n;
    logic [WW-1:0] wait_cnt, wait_cnt_n;
    logic [7:0]    err_count;

    logic [IW-1:0] enc_idx;
    logic          hit;
    logic          req;
    logic          strobe;
    logic [IW-1:0] strobe_idx;
    logic          ready;
    logic          error;
    logic          err_inc;
    logic [DATA_W-1:0] rdata;

    logic [DATA_W-1:0]    rd_arr [N_DEVICES];
    logic [N_DEVICES-1:0] ren_v;
    logic [N_DEVICES-1:0] wen_v;

    prio_encoder_n #(.N(N_DEVICES)) u_prio (
        .vec   (bus.device_active),
        .idx   (enc_idx),
        .valid (hit)
    );

    assign req = bus.host_ren | bus.host_wen;

    // Per-device broadcast, read-data slicing and strobe gating.
    for (genvar g = 0; g < N_DEVICES; g++) begin : g_dev
        assign bus.device_address[g*ADDR_W +: ADDR_W]  = bus.host_address;
        assign bus.device_data_write[g*DATA_W +: DATA_W] = bus.host_data_write;
        assign bus.device_write_mask[g*MW +: MW]        = bus.host_write_mask;
        assign rd_arr[g] = bus.device_data_read[g*DATA_W +: DATA_W];
        assign ren_v[g]  = strobe && !rst && bus.host_ren && (strobe_idx == IW'(g));
        assign wen_v[g]  = strobe && !rst && bus.host_wen && (strobe_idx == IW'(g));
    end

    assign bus.device_ren     = ren_v;
    assign bus.device_wen     = wen_v;
    assign bus.host_ready     = ready && !rst;
    assign bus.host_error     = error && !rst;
    assign bus.host_data_read = rst ? '0 : rdata;
    assign bus.err_count      = err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel_idx   <= '0;
            wait_cnt  <= '0;
            err_count <= '0;
        end else begin
            state    <= state_n;
            sel_idx  <= sel_idx_n;
            wait_cnt <= wait_cnt_n;
            if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
    end

    always_comb begin
        state_n    = state;
        sel_idx_n  = sel_idx;
        wait_cnt_n = wait_cnt;
        strobe     = 1'b0;
        strobe_idx = sel_idx;
        ready      = 1'b0;
        error      = 1'b0;
        err_inc    = 1'b0;
        rdata      = '0;
        case (state)
            IDLE: begin
                if (req && hit) begin
                    strobe     = 1'b1;
                    strobe_idx = enc_idx;
                    if (bus.device_ready[enc_idx]) begin
                        ready = 1'b1;
                        rdata = rd_arr[enc_idx];
                    end else begin
                        state_n    = BUSY;
                        sel_idx_n  = enc_idx;
                        wait_cnt_n = WW'(1);
                    end
                end else if (req) begin
                    ready   = 1'b1;
                    error   = 1'b1;
                    err_inc = 1'b1;
                end
            end
            BUSY: begin
                // A dropped request aborts silently; ready beats timeout.
                if (!req) begin
                    state_n = IDLE;
                end else if (bus.device_ready[sel_idx]) begin
                    strobe  = 1'b1;
                    ready   = 1'b1;
                    rdata   = rd_arr[sel_idx];
                    state_n = IDLE;
                end else if ((TIMEOUT != 0) && (wait_cnt == WW'(TIMEOUT))) begin
                    ready   = 1'b1;
                    error   = 1'b1;
                    rdata   = ERR_DATA;
                    err_inc = 1'b1;
                    state_n = IDLE;
                end else begin
                    strobe     = 1'b1;
                    wait_cnt_n = wait_cnt + WW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_hub_n.sv
// Directed self-checking bench for bus_hub_n (N=4, TIMEOUT=8).
module tb_bus_hub_n;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    bus_hub_n_if #(.N_DEVICES(4), .ADDR_W(32), .DATA_W(32)) bus ();

    bus_hub_n #(
        .N_DEVICES (4),
        .ADDR_W    (32),
        .DATA_W    (32),
        .TIMEOUT   (8),
        .ERR_DATA  (32'hDEAD_BEEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dev(input logic [3:0] active, input logic [3:0] rdy,
                           input logic ren, input logic wen);
        bus.device_active = active;
        bus.device_ready  = rdy;
        bus.host_ren      = ren;
        bus.host_wen      = wen;
    endtask

    initial begin
        rst = 1'b1;
        bus.host_address     = 32'h8000_0010;
        bus.host_data_write  = 32'h5555_AAAA;
        bus.host_write_mask  = 4'hF;
        bus.device_data_read = {32'hCAFE_0003, 32'h1234_5678, 32'h1111_1111, 32'h0000_00A0};
        set_dev(4'b0100, 4'b0100, 1'b1, 1'b0);

        // Reset: everything quiet even with a live request
        @(negedge clk);
        check("rst_ren",   64'(bus.device_ren), 64'h0);
        check("rst_ready", 64'(bus.host_ready), 64'h0);
        check("rst_error", 64'(bus.host_error), 64'h0);
        check("rst_errcnt", 64'(bus.err_count), 64'h0);
        check("rst_rdata", 64'(bus.host_data_read), 64'h0);

        // Zero-wait read from device 2
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("zw_ready", 64'(bus.host_ready), 64'h1);
        check("zw_rdata", 64'(bus.host_data_read), 64'h1234_5678);
        check("zw_ren",   64'(bus.device_ren), 64'b0100);
        check("zw_error", 64'(bus.host_error), 64'h0);
        check("bcast_addr", 64'(bus.device_address[3*32 +: 32]), 64'h8000_0010);
        check("bcast_mask", 64'(bus.device_write_mask), 64'hFFFF);

        // Devices 1 and 3 active; device 3 completes at C2
        next_cycle();
        set_dev(4'b0000, 4'b0000, 1'b0, 1'b0);
        next_cycle();
        set_dev(4'b1010, 4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        check("pr_c0_ren",   64'(bus.device_ren), 64'b1000);
        check("pr_c0_ready", 64'(bus.host_ready), 64'h0);
        check("pr_c0_rdata", 64'(bus.host_data_read), 64'h0);
        next_cycle();
        set_dev(4'b0001, 4'b0010, 1'b1, 1'b0);
        @(negedge clk);
        check("pr_c1_ren",   64'(bus.device_ren), 64'b1000);
        check("pr_c1_ready", 64'(bus.host_ready), 64'h0);
        next_cycle();
        set_dev(4'b1010, 4'b1000, 1'b1, 1'b0);
        @(negedge clk);
        check("pr_c2_ready", 64'(bus.host_ready), 64'h1);
        check("pr_c2_rdata", 64'(bus.host_data_read), 64'hCAFE_0003);
        check("pr_c2_ren",   64'(bus.device_ren), 64'b1000);
        check("pr_c2_error", 64'(bus.host_error), 64'h0);

        // Unmapped write
        next_cycle();
        set_dev(4'b0000, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        check("um_ready", 64'(bus.host_ready), 64'h1);
        check("um_error", 64'(bus.host_error), 64'h1);
        check("um_wen",   64'(bus.device_wen), 64'h0);
        check("um_rdata", 64'(bus.host_data_read), 64'h0);
        check("um_errcnt0", 64'(bus.err_count), 64'h0);
        next_cycle();
        set_dev(4'b0000, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        check("um_errcnt1", 64'(bus.err_count), 64'h1);

        // Timeout on device 0, then a back-to-back zero-wait access
        next_cycle();
        set_dev(4'b0001, 4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("to_hold_ren",   64'(bus.device_ren), 64'b0001);
            check("to_hold_ready", 64'(bus.host_ready), 64'h0);
            next_cycle();
        end
        @(negedge clk);
        check("to_ren",   64'(bus.device_ren), 64'h0);
        check("to_ready", 64'(bus.host_ready), 64'h1);
        check("to_error", 64'(bus.host_error), 64'h1);
        check("to_rdata", 64'(bus.host_data_read), 64'hDEAD_BEEF);
        next_cycle();
        set_dev(4'b0100, 4'b0100, 1'b1, 1'b0);
        @(negedge clk);
        check("b2b_ready",  64'(bus.host_ready), 64'h1);
        check("b2b_rdata",  64'(bus.host_data_read), 64'h1234_5678);
        check("b2b_ren",    64'(bus.device_ren), 64'b0100);
        check("b2b_errcnt", 64'(bus.err_count), 64'h2);

        // Ready arriving in the timeout cycle wins
        next_cycle();
        set_dev(4'b0001, 4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) next_cycle();
        bus.device_ready = 4'b0001;
        @(negedge clk);
        check("rw_ready",  64'(bus.host_ready), 64'h1);
        check("rw_error",  64'(bus.host_error), 64'h0);
        check("rw_rdata",  64'(bus.host_data_read), 64'h0000_00A0);
        check("rw_errcnt", 64'(bus.err_count), 64'h2);

        // Reset at C3 of a BUSY access
        next_cycle();
        set_dev(4'b0001, 4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("mr_ren",    64'(bus.device_ren), 64'h0);
        check("mr_ready",  64'(bus.host_ready), 64'h0);
        check("mr_error",  64'(bus.host_error), 64'h0);
        check("mr_errcnt", 64'(bus.err_count), 64'h0);
        next_cycle();
        rst = 1'b0;
        set_dev(4'b0100, 4'b0100, 1'b1, 1'b0);
        @(negedge clk);
        check("pr_ready", 64'(bus.host_ready), 64'h1);
        check("pr_rdata", 64'(bus.host_data_read), 64'h1234_5678);
        next_cycle();
        set_dev(4'b0000, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        check("pr_errcnt", 64'(bus.err_count), 64'h0);

        // 300 unmapped accesses saturate the error counter
        next_cycle();
        set_dev(4'b0000, 4'b0000, 1'b0, 1'b1);
        repeat (254) next_cycle();
        check("sat_254", 64'(bus.err_count), 64'd254);
        next_cycle();
        check("sat_255", 64'(bus.err_count), 64'd255);
        repeat (45) next_cycle();
        check("sat_300", 64'(bus.err_count), 64'd255);
        check("sat_error", 64'(bus.host_error), 64'h1);
        set_dev(4'b0000, 4'b0000, 1'b0, 1'b0);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_hub_n.md
# bus_hub_n

Parametrised host-to-N-device bus hub for the CPU data/instruction bus, with self-demultiplexing via per-device `device_active` decode lines. It adds a transaction FSM that latches the selected device for the whole access, so `host_ready` and `host_data_read` come only from that device. Unmapped accesses are answered with an error, as are stalled devices after a programmable timeout. It sits between the core's memory port and the RAM/ROM/peripheral devices.

## Interface
Parameters:
- `N_DEVICES`, 4: number of device ports, ≥1.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; mask width is DATA_W/8.
- `TIMEOUT`, 255: wait cycles before a timeout error; 0 disables the timeout.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `host_address` in ADDR_W: request address, held until `host_ready`.
- `host_data_write` in DATA_W: write data.
- `host_write_mask` in DATA_W/8: byte enables.
- `host_ren`, `host_wen` in 1: request strobes, mutually exclusive, held until `host_ready`.
- `host_data_read` out DATA_W: read data, valid when `host_ready`.
- `host_ready` out 1: access complete this cycle.
- `host_error` out 1: completion is an error (unmapped or timeout); qualified by `host_ready`.
- `device_address` out N*ADDR_W: `host_address` broadcast to every slice.
- `device_data_write` out N*DATA_W: broadcast.
- `device_write_mask` out N*DATA_W/8: broadcast.
- `device_ren`, `device_wen` out N: gated strobes, at most one bit set.
- `device_ready` in N: per-device completion.
- `device_data_read` in N*DATA_W: per-device read data.
- `device_active` in N: per-device address decode.
- `err_count` out 8: saturating count of error completions.

## Operation
- FSM states: IDLE, BUSY. Registers: `state`, `sel_idx` ($clog2(N) bits), `wait_cnt` ($clog2(TIMEOUT+1) bits), `err_count`.
- Request: `req = host_ren | host_wen`.
- Device selection in IDLE is live: `idx` = highest set bit of `device_active`; `hit = |device_active`.
- IDLE with `req` and `hit`:
  - Strobe device `idx` combinationally.
  - If `device_ready[idx]`: `host_ready=1`, data from `idx`, stay IDLE (zero-wait).
  - Otherwise: go to BUSY, `sel_idx<=idx`, `wait_cnt<=1`.
- IDLE with `req` and no `hit`:
  - `host_ready=1`, `host_error=1`, `host_data_read=0`, no device strobed.
  - `err_count` increments; stay IDLE.
- BUSY:
  - Strobe only device `sel_idx`; `device_active` changes are ignored.
  - If `device_ready[sel_idx]`: complete with that device's data, go to IDLE.
  - Else, if `TIMEOUT!=0` and `wait_cnt==TIMEOUT`: the strobe is forced to 0. Then `host_ready=1`, `host_error=1`, data=`ERR_DATA`, `err_count` increments, go to IDLE.
  - Else `wait_cnt` increments.
- Host drops `req` in BUSY (protocol violation): go to IDLE, no `host_ready`, no error.
- `device_ready` from any device other than the selected one is ignored.
- `host_data_read` is 0 whenever `host_ready=0`.
- `err_count` saturates at 255.

## Timing
- Reset values: `state=IDLE`, `sel_idx=0`, `wait_cnt=0`, `err_count=0`.
- While `rst` is high, all `device_ren`/`device_wen`, `host_ready` and `host_error` are 0.
- Reset mid-BUSY aborts the access with no completion.
- Latency, counted from the request cycle C0:
  - Device ready at C0: completes at C0.
  - Device ready at Ck: completes at Ck.
  - Timeout completion at C(TIMEOUT), provided no ready occurred before.
- Ready arriving in the timeout cycle itself: ready wins, normal completion.
- Back-to-back: the host may present a new request in the cycle after `host_ready`; IDLE accepts it with no gap.
- Broadcast outputs are purely combinational from host inputs.

## Structure
- Package `bus_pkg`:
  - `hub_state_t` enum {IDLE, BUSY}.
  - Localparams for default ADDR_W/DATA_W.
  - `ERR_DATA_DEFAULT`.
- Sub-module `prio_encoder_n` (N-bit input → highest-set index plus `valid`), reusable by other decoders.
- Generate loop for per-device slicing and strobe gating.

## Test plan
- N=4, device 2 active and ready at C0, `host_ren`: `host_ready` at C0, data = device 2's `32'h1234_5678`, `device_ren=4'b0100`, `host_error=0`.
- Devices 1 and 3 both active, device 3 ready at C2: only `device_ren[3]` is strobed. Completion at C2 with device 3 data; a concurrent `device_ready[1]` pulse is ignored.
- Write with `device_active=0`: `host_ready` and `host_error` at C0, `device_wen=0`, `err_count` goes 0→1.
- TIMEOUT=8, device 0 never ready: strobe held C0–C7. At C8, strobe is 0, `host_ready=1`, `host_error=1`, data `DEAD_BEEF`, and the next cycle is IDLE.
- Reset asserted at C3 of a BUSY access: outputs go to 0 immediately. A new access after reset completes normally and `err_count` stays 0.
- 300 unmapped accesses: `err_count` saturates at 255.
